// File: rtl/music_strip_pkg.sv
// Shared types and constants for the music-strip spectrum path.
// Holds the band_decay state encoding and the common level width.
package music_strip_pkg;

  localparam int LVL_W = 8;

  typedef enum logic [1:0] {
    BD_IDLE  = 2'd0,
    BD_DECAY = 2'd1,
    BD_EMIT  = 2'd2
  } bd_state_e;

  function automatic logic [LVL_W-1:0] lvl_max(input logic [LVL_W-1:0] a,
                                               input logic [LVL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/band_decay.sv
// Peak-hold spectrum store: accepts band levels, decays every band by x0.99 once
// per frame through an external scaler, then streams all bands out in order.
module band_decay
  import music_strip_pkg::*;
#(
  parameter int N_BANDS = 16,
  parameter int BAND_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              lvl_valid,
  input  logic [BAND_W-1:0] lvl_band,
  input  logic [LVL_W-1:0]  lvl_value,
  output logic              lvl_ready,
  output logic [LVL_W-1:0]  mul_in,
  input  logic [LVL_W-1:0]  mul_out,
  output logic              out_valid,
  output logic [BAND_W-1:0] out_band,
  output logic [LVL_W-1:0]  out_value,
  input  logic              out_ready,
  output logic              overrun
);

  localparam logic [BAND_W-1:0] LAST_IDX = BAND_W'(N_BANDS - 1);

  logic [LVL_W-1:0]  mem [N_BANDS];
  bd_state_e         state, state_n;
  logic [BAND_W-1:0] idx, idx_n;
  logic              pending, pending_n;
  logic              overrun_q, overrun_n;

  logic              mem_we;
  logic [BAND_W-1:0] mem_wa;
  logic [LVL_W-1:0]  mem_wd;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    overrun_n = overrun_q;
    mem_we    = 1'b0;
    mem_wa    = lvl_band;
    mem_wd    = lvl_value;
    lvl_ready = 1'b0;
    mul_in    = '0;
    out_valid = 1'b0;
    out_band  = idx;
    out_value = mem[idx];

    // A tick while busy is remembered once; a second one is lost and flagged.
    if (frame_tick && (state != BD_IDLE)) begin
      if (pending) overrun_n = 1'b1;
      else         pending_n = 1'b1;
    end

    case (state)
      BD_IDLE: begin
        lvl_ready = 1'b1;
        mem_wd    = lvl_max(mem[lvl_band], lvl_value);
        mem_we    = lvl_valid;
        if (frame_tick) begin
          state_n = BD_DECAY;
          idx_n   = '0;
        end
      end

      BD_DECAY: begin
        mul_in = mem[idx];
        mem_we = 1'b1;
        mem_wa = idx;
        mem_wd = mul_out;
        if (idx == LAST_IDX) begin
          state_n = BD_EMIT;
          idx_n   = '0;
        end else begin
          idx_n = idx + BAND_W'(1);
        end
      end

      BD_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            idx_n     = '0;
            // Pending work (or a tick landing right now) chains straight into DECAY.
            state_n   = (pending || frame_tick) ? BD_DECAY : BD_IDLE;
            pending_n = 1'b0;
          end else begin
            idx_n = idx + BAND_W'(1);
          end
        end
      end

      default: begin
        state_n = BD_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BD_IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the level store is a small register array, so it is cleared on reset like any other state.
      for (int i = 0; i < N_BANDS; i++) mem[i] <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pending   <= pending_n;
      overrun_q <= overrun_n;
      if (mem_we) mem[mem_wa] <= mem_wd;
    end
  end

  assign overrun = overrun_q;

endmodule
